// File: rtl/msk_freq_ctrl.sv
// MSK symbol-to-frequency controller: buffers serial bits and drives the NCO deviation word.
// Optional differential encoding of the data bits is enabled by defining MSK_DIFF_ENC_EN.
module msk_freq_ctrl #(
  parameter int unsigned FW         = 25,
  parameter int unsigned FDEV       = 2097152,
  parameter int unsigned SPS        = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clken,
  input  logic          enable,
  input  logic          din,
  input  logic          din_valid,
  output logic          din_ready,
  output logic [FW-1:0] freq_mod_o,
  output logic          sym_strobe,
  output logic          busy,
  output logic          underflow
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(SPS);
  localparam logic [AW:0]    FullCnt = FIFO_DEPTH[AW:0];
  localparam logic [CW-1:0]  CntLast = CW'(SPS - 1);
  localparam logic [FW-1:0]  DevPos  = FW'(FDEV);
  localparam logic [FW-1:0]  DevNeg  = -DevPos;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [FW-1:0] freq_q, freq_d;
  logic          strobe_q, strobe_d;
  logic          under_q, under_d;

  logic          fifo_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          full, empty, wr_en, pop, head;

  logic          apply, sym_bit, enc_bit, clr_enc;

  // ---------------- bit FIFO ----------------
  assign full    = (count_q == FullCnt);
  assign empty   = (count_q == '0);
  assign wr_en   = din_valid & ~full;
  assign head    = fifo_q[rd_ptr_q];
  assign count_d = count_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (wr_en) fifo_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // ---------------- symbol FSM ----------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    freq_d   = freq_q;
    strobe_d = 1'b0;
    under_d  = under_q;
    pop      = 1'b0;
    apply    = 1'b0;
    sym_bit  = 1'b0;
    clr_enc  = 1'b0;

    if (clken) begin
      unique case (state_q)
        StIdle: begin
          cnt_d = '0;
          if (enable && !empty) begin
            state_d = StRun;
            pop     = 1'b1;
            apply   = 1'b1;
            sym_bit = head;
            under_d = 1'b0;
          end
        end
        StRun: begin
          if (cnt_q == CntLast) begin
            cnt_d = '0;
            if (!enable) begin
              state_d = StIdle;
              freq_d  = '0;
              clr_enc = 1'b1;
            end else if (!empty) begin
              pop     = 1'b1;
              apply   = 1'b1;
              sym_bit = head;
            end else begin
              // Starved: keep the carrier modulated with a zero bit and flag it.
              apply   = 1'b1;
              under_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (apply) begin
      freq_d   = enc_bit ? DevPos : DevNeg;
      strobe_d = 1'b1;
    end
  end

`ifdef MSK_DIFF_ENC_EN
  logic eprev_q;

  assign enc_bit = sym_bit ^ eprev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      eprev_q <= 1'b0;
    end else if (clr_enc) begin
      eprev_q <= 1'b0;
    end else if (apply) begin
      eprev_q <= enc_bit;
    end
  end
`else
  assign enc_bit = sym_bit;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      freq_q   <= '0;
      strobe_q <= 1'b0;
      under_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      freq_q   <= freq_d;
      strobe_q <= strobe_d;
      under_q  <= under_d;
    end
  end

  assign din_ready  = ~full;
  assign freq_mod_o = freq_q;
  assign sym_strobe = strobe_q;
  assign busy       = (state_q == StRun);
  assign underflow  = under_q;

endmodule
